// File: rtl/spi_pkg.sv
// Shared definitions for the SPI command/data initiator: opcodes, widths and FSM states.
package spi_pkg;

    localparam int CMD_W  = 10;
    localparam int DATA_W = 8;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_OUT,
        GAP,
        SHIFT_IN,
        SS_HOLD
    } state_e;

endpackage

// File: rtl/spi_sck_gen.sv
// SPI clock generator: toggles sck every CLK_DIV cycles while enabled and flags the
// cycle on which sck is about to rise or fall.
module spi_sck_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    output logic sck_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CW = $clog2(CLK_DIV + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sck_q, sck_d;
    logic          wrap;

    assign wrap = en_i && (cnt_q == CW'(CLK_DIV - 1));

    always_comb begin
        cnt_d = cnt_q;
        sck_d = sck_q;
        if (!en_i) begin
            cnt_d = '0;
            sck_d = 1'b0;
        end else if (wrap) begin
            cnt_d = '0;
            sck_d = ~sck_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            sck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sck_q <= sck_d;
        end
    end

    // Strobes mark the clk edge on which sck changes, so the FSM acts in lockstep with it.
    assign sck_o  = sck_q;
    assign rise_o = wrap && !sck_q;
    assign fall_o = wrap && sck_q;

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 initiator: serialises 10-bit commands MSB first and, for read-data
// commands, clocks back one byte after an optional idle gap.
module spi_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int RD_GAP  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CMD_W-1:0]  cmd_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic              sck,
    output logic              ss_n,
    output logic              mosi,
    input  logic              miso
);

    localparam int BW = $clog2(18 + RD_GAP + 1);
    localparam int HW = $clog2(2 * CLK_DIV);

    state_e            state_q, state_d;
    logic [CMD_W-1:0]  shift_q, shift_d;
    logic [1:0]        op_q, op_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic [DATA_W-1:0] rsp_q, rsp_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              ss_n_q, ss_n_d;
    logic              sck_en, sck_rise, sck_fall;

    assign sck_en = (state_q == SHIFT_OUT) || (state_q == GAP) || (state_q == SHIFT_IN);

    spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (sck_en),
        .sck_o  (sck),
        .rise_o (sck_rise),
        .fall_o (sck_fall)
    );

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        op_d        = op_q;
        bit_d       = bit_q;
        hold_d      = hold_q;
        rx_d        = rx_q;
        rsp_d       = rsp_q;
        rsp_valid_d = 1'b0;
        ss_n_d      = ss_n_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d = SHIFT_OUT;
                    shift_d = cmd_data;
                    op_d    = cmd_data[9:8];
                    bit_d   = '0;
                    ss_n_d  = 1'b0;
                end
            end
            SHIFT_OUT: begin
                if (sck_fall) begin
                    if (bit_q == BW'(CMD_W - 1)) begin
                        bit_d = '0;
                        if (op_q == CMD_RD_DATA) begin
                            state_d = (RD_GAP > 0) ? GAP : SHIFT_IN;
                        end else begin
                            state_d = SS_HOLD;
                            ss_n_d  = 1'b1;
                            hold_d  = '0;
                        end
                    end else begin
                        bit_d   = bit_q + BW'(1);
                        shift_d = {shift_q[CMD_W-2:0], 1'b0};
                    end
                end
            end
            GAP: begin
                if (sck_fall) begin
                    if (bit_q == BW'(RD_GAP - 1)) begin
                        state_d = SHIFT_IN;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            SHIFT_IN: begin
                if (sck_rise) begin
                    rx_d = {rx_q[DATA_W-2:0], miso};
                end
                if (sck_fall) begin
                    if (bit_q == BW'(DATA_W - 1)) begin
                        rsp_d       = rx_q;
                        rsp_valid_d = 1'b1;
                        ss_n_d      = 1'b1;
                        hold_d      = '0;
                        state_d     = SS_HOLD;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            SS_HOLD: begin
                // IDLE is entered on the edge that ends the deselect window; the next accept follows.
                if (hold_q == HW'(2 * CLK_DIV - 1)) begin
                    state_d = IDLE;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            op_q        <= '0;
            bit_q       <= '0;
            hold_q      <= '0;
            rx_q        <= '0;
            rsp_q       <= '0;
            rsp_valid_q <= 1'b0;
            ss_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            op_q        <= op_d;
            bit_q       <= bit_d;
            hold_q      <= hold_d;
            rx_q        <= rx_d;
            rsp_q       <= rsp_d;
            rsp_valid_q <= rsp_valid_d;
            ss_n_q      <= ss_n_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = !cmd_ready;
    assign ss_n      = ss_n_q;
    assign mosi      = (state_q == SHIFT_OUT) && shift_q[CMD_W-1];
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_q;

endmodule

// File: doc/spi_master.md
# spi_master

SPI initiator that drives the command/data protocol understood by the team's SPI slave plus single-port RAM subsystem. It accepts 10-bit command words (2-bit opcode and 8-bit payload) from a local host, serialises them MSB-first on MOSI, and for read-data commands clocks back one 8-bit byte on MISO. It sits on the host side of the SPI link, opposite the slave/RAM pair.

## Interface
- CLK_DIV, 2, SCK half-period in clk cycles (legal values ≥1)
- RD_GAP, 1, idle SCK periods between the command bits and the first MISO data bit on opcode 11 (legal values ≥0)
- clk  in  1  system clock; all logic on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  host presents cmd_data
- cmd_ready  out  1  master idle; a command is accepted when cmd_valid && cmd_ready
- cmd_data  in  10  [9:8] opcode (00 write addr, 01 write data, 10 read addr, 11 read data), [7:0] payload
- rsp_valid  out  1  one-cycle pulse: rsp_data holds the byte read by opcode 11
- rsp_data  out  8  last read byte; held until the next opcode-11 completion
- busy  out  1  equals !cmd_ready
- sck  out  1  SPI clock, mode 0, idle low
- ss_n  out  1  slave select, active low
- mosi  out  1  serial data to slave
- miso  in  1  serial data from slave, same clock domain as clk

## Operation
- Reset values: cmd_ready=1, busy=0, rsp_valid=0, rsp_data=0, sck=0, ss_n=1, mosi=0, state IDLE. Reset mid-transaction aborts immediately; no rsp_valid is issued.
- FSM states: IDLE, SHIFT_OUT, GAP, SHIFT_IN, SS_HOLD.
- IDLE: cmd_ready=1. On accept, latch cmd_data into a 10-bit shift register, drive ss_n=0, mosi=cmd_data[9], and go to SHIFT_OUT.
- SHIFT_OUT: 10 SCK periods. MOSI changes only after SCK falling edges, and the slave samples it on the rising edge. After the 10th falling edge:
  - opcode 11 goes to GAP if RD_GAP>0, otherwise to SHIFT_IN;
  - all other opcodes go to SS_HOLD.
- GAP: RD_GAP SCK periods with mosi=0 and MISO ignored, then SHIFT_IN.
- SHIFT_IN: 8 SCK periods with mosi=0. MISO is sampled on each SCK rising edge into rsp_data's shift register, MSB first. After the 8th falling edge, update rsp_data, pulse rsp_valid, and go to SS_HOLD.
- SS_HOLD: ss_n=1 and sck=0 for 2*CLK_DIV cycles, then IDLE. This guarantees minimum deselect time between frames.
- cmd_valid while busy is ignored. The host must hold cmd_valid until it is accepted.
- No other output changes during a frame.

## Timing
- Accept at edge T. At T, ss_n falls and mosi=bit9.
- SCK rises at T+(2k+1)*CLK_DIV and falls at T+(2k+2)*CLK_DIV, for bit k=0..N-1.
- Frame length N: 10 for opcodes 00/01/10; 18+RD_GAP for opcode 11.
- ss_n rises at T+2*N*CLK_DIV, together with sck=0 and mosi=0. rsp_valid is high for the single cycle following that edge (opcode 11 only).
- cmd_ready rises at T+(2N+2)*CLK_DIV. Earliest next accept is on that edge.
- A bit counter wraps only within a frame. Counters are sized for the max frame of 18+RD_GAP bits and for CLK_DIV.

## Structure
- Shared package spi_pkg holds:
  - opcode constants: CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11;
  - CMD_W=10, DATA_W=8;
  - the FSM state encoding.
- One sub-module, spi_sck_gen: CLK_DIV counter producing sck and one-cycle rise/fall strobes. Enabled by the FSM and cleared to sck=0 when disabled.

## Test plan
- Reset: assert rst_n=0 mid-frame, with CLK_DIV=2 and opcode 01 at bit 5. Required: ss_n=1, sck=0, mosi=0, cmd_ready=1 asynchronously; no rsp_valid afterwards.
- Write address: cmd_data=10'h0A5 (00_10100101), CLK_DIV=2. Required: MOSI sampled at 10 rising edges = 0,0,1,0,1,0,0,1,0,1; ss_n high at T+40; cmd_ready at T+44.
- Write data then read back: opcodes 00/0x12, 01/0x3C, 10/0x12, 11/0x00 against a slave+RAM model. Required: the 11 frame is 19 SCK periods (RD_GAP=1); rsp_valid pulses once at T+76 with rsp_data=0x3C; cmd_ready at T+80.
- Back-to-back: cmd_valid held high with four queued commands. Required: each accepted exactly on its cmd_ready rising edge; ss_n high ≥2*CLK_DIV cycles between frames.
- Parameter sweep: CLK_DIV=1 and RD_GAP=0, opcode 11 with the slave returning 0xFF, then 0x00. Required: 18-period frame; rsp_data=0xFF, then 0x00; rsp_data held between reads.
- Busy ignore: pulse cmd_valid for one cycle mid-frame. Required: no accept, frame and shift register unaffected.
